// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//
// Initiator side of the external SRAM interface. Sits between the MEM stage
// and the off-chip SRAM and turns a single-word load/store request into a
// multi-cycle SRAM access. While an access is in flight `ready` is held low,
// which freezes the pipeline. A read returns the addressed word plus the
// full even/odd word pair seen on the 64-bit SRAM data bus.
//
// Ports:
//   clk         in   single clock, all state updates on posedge
//   rst         in   synchronous reset, active-high
//   wr_en       in   store request, held by the pipeline until ready
//   rd_en       in   load request, held by the pipeline until ready
//   address     in   32-bit byte address
//   wdata       in   store data (DATA_LEN)
//   rdata       out  loaded word, registered (DATA_LEN)
//   rline       out  loaded word pair {odd, even}, registered (2*DATA_LEN)
//   ready       out  no access pending, or the current access completes now
//   sram_we_en  out  0 = write strobe, 1 = read / idle
//   sram_addr   out  SRAM word address (ADDR_LEN)
//   sram_dq     io   SRAM data bus (2*DATA_LEN); only the low word is ever
//                    driven, and only during the busy phase of a write
// ---------------------------------------------------------------------------
module sram_controller #(
  parameter int ADDR_LEN    = 18,
  parameter int DATA_LEN    = 32,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [31:0]           address,
  input  logic [DATA_LEN-1:0]   wdata,
  output logic [DATA_LEN-1:0]   rdata,
  output logic [2*DATA_LEN-1:0] rline,
  output logic                  ready,
  output logic                  sram_we_en,
  output logic [ADDR_LEN-1:0]   sram_addr,
  inout  wire  [2*DATA_LEN-1:0] sram_dq
);

  // Counter is at least 3 bits wide and large enough to reach WAIT_CYCLES-1.
  localparam int CNT_W = ($clog2(WAIT_CYCLES) > 3) ? $clog2(WAIT_CYCLES) : 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0]      BASE_C   = 32'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_LEN-1:0]     addr_q, addr_d;
  logic [DATA_LEN-1:0]     wdata_q, wdata_d;
  logic                    op_wr_q, op_wr_d;
  logic [DATA_LEN-1:0]     rdata_q, rdata_d;
  logic [2*DATA_LEN-1:0]   rline_q, rline_d;

  logic [31:0]             offset_s;
  logic [ADDR_LEN-1:0]     word_addr_s;
  logic                    drive_s;
  logic                    ready_s;
  logic                    we_en_s;
  logic                    unused_s;

  // Byte offset from the SRAM base wraps modulo 2^32; no range check is done,
  // so out-of-range addresses simply alias onto SRAM words.
  assign offset_s    = address - BASE_C;
  assign word_addr_s = offset_s[ADDR_LEN+1:2];
  assign unused_s    = ^{offset_s[31:ADDR_LEN+2], offset_s[1:0]};

  // Only the low word carries write data; the high word is never driven.
  // drive_s implies sram_we_en is low, so the SRAM and controller never
  // fight over the bus.
  assign sram_dq = drive_s ? {{DATA_LEN{1'bz}}, wdata_q}
                           : {(2*DATA_LEN){1'bz}};

  // The latched address stays on the bus outside BUSY as well; it is only
  // meaningful while sram_we_en qualifies it.
  assign sram_addr  = addr_q;
  assign sram_we_en = we_en_s;
  assign ready      = ready_s;
  assign rdata      = rdata_q;
  assign rline      = rline_q;

  // State, counter, latched request and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      rline_q <= rline_d;
    end
  end

  // Next-state logic, request latching, read capture and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    rdata_d = rdata_q;
    rline_d = rline_q;
    ready_s = 1'b0;
    we_en_s = 1'b1;
    drive_s = 1'b0;

    case (state_q)
      IDLE: begin
        ready_s = ~wr_en & ~rd_en;
        if (wr_en | rd_en) begin
          // A simultaneous load and store is treated as a store only.
          addr_d  = word_addr_s;
          wdata_d = wdata;
          op_wr_d = wr_en;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        we_en_s = ~op_wr_q;
        drive_s = op_wr_q;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          if (!op_wr_q) begin
            // SRAM presents the whole even/odd pair; bit 0 picks the word.
            rline_d = sram_dq;
            if (addr_q[0]) begin
              rdata_d = sram_dq[2*DATA_LEN-1:DATA_LEN];
            end else begin
              rdata_d = sram_dq[DATA_LEN-1:0];
            end
          end else begin
            rline_d = rline_q;
          end
        end else begin
          state_d = BUSY;
        end
      end

      DONE: begin
        // The pipeline advances this cycle, so whatever request is seen in
        // the following IDLE is a new access.
        ready_s = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

  localparam int WAITC = 5;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [63:0] rline;
  logic        ready;
  logic        sram_we_en;
  logic [17:0] sram_addr;
  wire  [63:0] sram_dq;

  sram_controller #(
    .ADDR_LEN(18), .DATA_LEN(32), .BASE_ADDR(1024), .WAIT_CYCLES(WAITC)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .wdata(wdata), .rdata(rdata), .rline(rline),
    .ready(ready), .sram_we_en(sram_we_en), .sram_addr(sram_addr),
    .sram_dq(sram_dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small SRAM model: 16 words, drives the even/odd pair whenever not written.
  logic        model_clr;
  logic [31:0] mem [16];

  assign sram_dq = sram_we_en ? {mem[{sram_addr[3:1], 1'b1}], mem[{sram_addr[3:1], 1'b0}]}
                              : {64{1'bz}};

  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    end else if (!sram_we_en) begin
      mem[sram_addr[3:0]] <= sram_dq[31:0];
    end
  end

  typedef struct {
    bit          is_wr;
    logic [31:0] rdata;
    logic [63:0] rline;
    logic [17:0] addr;
    logic [31:0] wdata;
    int          issue;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_done = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: counts write-strobe cycles of the current access and, when ready
  // rises after a pending access, pops and checks the expected response.
  initial begin : monitor
    logic ready_prev;
    logic rst_prev;
    int   we_low;
    bit   addr_bad;
    bit   dq_bad;
    exp_t e;
    ready_prev = 1'b1;
    rst_prev   = 1'b1;
    we_low     = 0;
    addr_bad   = 1'b0;
    dq_bad     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_low   = 0;
        addr_bad = 1'b0;
        dq_bad   = 1'b0;
      end else begin
        if (!sram_we_en && q.size() > 0) begin
          we_low++;
          if (sram_addr !== q[0].addr) addr_bad = 1'b1;
          if (sram_dq[31:0] !== q[0].wdata) dq_bad = 1'b1;
        end
        if (ready && !ready_prev && !rst_prev) begin
          if (q.size() == 0) begin
            chk("spurious_done", 64'(q.size()), 64'd1);
          end else begin
            e = q.pop_front();
            chk("latency", 64'(cyc - e.issue), 64'(WAITC + 1));
            chk("rdata", 64'(rdata), 64'(e.rdata));
            chk("rline", rline, e.rline);
            chk("strobe_cycles", 64'(we_low), e.is_wr ? 64'(WAITC) : 64'd0);
            chk("strobe_addr", 64'(addr_bad), 64'd0);
            if (e.is_wr) chk("write_dq", 64'(dq_bad), 64'd0);
            last_done = cyc;
            we_low    = 0;
            addr_bad  = 1'b0;
            dq_bad    = 1'b0;
          end
        end
      end
      ready_prev = ready;
      rst_prev   = rst;
    end
  end

  task automatic issue(input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input bit push,
                       input logic [31:0] er, input logic [63:0] el);
    exp_t e;
    logic [31:0] off;
    off      = a - 32'd1024;
    wr_en    = w;
    rd_en    = r;
    address  = a;
    wdata    = d;
    if (push) begin
      e.is_wr = w;
      e.rdata = er;
      e.rline = el;
      e.addr  = off[19:2];
      e.wdata = d;
      e.issue = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("timeout_ready", 64'(ready), 64'd1);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin : stim
    int start;
    rst = 1'b1; model_clr = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; model_clr = 1'b0;
    @(negedge clk);
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("reset_rline", rline, 64'd0);
    chk("reset_we_en", 64'(sram_we_en), 64'd1);
    chk("reset_addr", 64'(sram_addr), 64'd0);
    chk("reset_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;

    // Single write to word 2.
    issue(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b1, 32'd0, 64'd0);
    wait_done();
    chk("mem2_write", 64'(mem[2]), 64'hDEADBEEF);

    // Preload words 2 and 3 through the controller.
    issue(1'b1, 1'b0, 32'd1032, 32'h11111111, 1'b1, 32'd0, 64'd0);
    wait_done();
    issue(1'b1, 1'b0, 32'd1036, 32'h22222222, 1'b1, 32'd0, 64'd0);
    wait_done();

    // Read even then odd half of the pair.
    issue(1'b0, 1'b1, 32'd1032, 32'd0, 1'b1, 32'h11111111, 64'h22222222_11111111);
    wait_done();
    issue(1'b0, 1'b1, 32'd1036, 32'd0, 1'b1, 32'h22222222, 64'h22222222_11111111);
    wait_done();

    // Simultaneous request: write wins, read data unchanged.
    issue(1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5, 1'b1, 32'h22222222, 64'h22222222_11111111);
    wait_done();
    chk("mem0_simul", 64'(mem[0]), 64'hA5A5A5A5);

    // Back-to-back write then read of word 4.
    start = cyc;
    issue(1'b1, 1'b0, 32'd1040, 32'h12345678, 1'b1, 32'h22222222, 64'h22222222_11111111);
    wait_done();
    issue(1'b0, 1'b1, 32'd1040, 32'd0, 1'b1, 32'h12345678, 64'h00000000_12345678);
    wait_done();
    chk("b2b_total", 64'(last_done - start), 64'(2 * WAITC + 3));

    // Reset in the middle of a read at cnt=2.
    issue(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0, 32'd0, 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_we_en", 64'(sram_we_en), 64'd1);
    chk("abort_rdata", 64'(rdata), 64'd0);
    chk("abort_rline", rline, 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;

    // Fresh read after the abort.
    issue(1'b0, 1'b1, 32'd1024, 32'd0, 1'b1, 32'hA5A5A5A5, 64'h00000000_A5A5A5A5);
    wait_done();

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
